// File: rtl/dmem_handshake.sv
// Multi-cycle data-memory responder with valid/ready request and response channels.
// RAM powers up uninitialised and holds only what has been stored.
module dmem_handshake #(
   parameter int DEPTH     = 64,
   parameter int LATENCY   = 2,
   parameter     INIT_FILE = "dmem.dat"
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   logic [63:0]   mem [DEPTH];

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          req_ready_q, req_ready_d;
   logic          resp_valid_q, resp_valid_d;
   logic          resp_err_q, resp_err_d;
   logic [63:0]   rdata_q, rdata_d;

   logic [AW-1:0] idx;
   logic          addr_err;
   logic          accept;
   logic          wr_en;

   assign idx      = req_addr[AW+2:3];
   assign addr_err = (req_addr[2:0] != 3'b000) || (|req_addr[63:AW+3]);
   assign accept   = req_valid && req_ready_q;
   assign wr_en    = accept && req_we && !addr_err;

   // Stores commit on the accept edge, so a later load always sees them.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 8; i++) begin
            if (req_wstrb[i]) begin
               mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      resp_err_d = resp_err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d      = 4'(LATENCY - 1);
               state_d    = (LATENCY == 1) ? RESP : WAIT;
               rdata_d    = (req_we || addr_err) ? 64'd0 : mem[idx];
               resp_err_d = addr_err;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d    = IDLE;
               rdata_d    = 64'd0;
               resp_err_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      req_ready_d  = (state_d == IDLE);
      resp_valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         rdata_q      <= 64'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         rdata_q      <= rdata_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_handshake.sv
// Directed self-checking bench for dmem_handshake at DEPTH=64, LATENCY=2.
module tb_dmem_handshake;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   int compared   = 0;
   int mismatched = 0;

   dmem_handshake #(.DEPTH(64), .LATENCY(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Full transaction starting just after an edge with the DUT idle; response expected 2 edges after accept.
   task automatic applyStimulus(input string tag, input logic we, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [7:0] wstrb,
                                input int hold, input logic early_ready,
                                input logic [63:0] exp_rdata, input logic exp_err);
      checkOutput({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      req_wstrb  = wstrb;
      resp_ready = early_ready;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_wdata = '1;
      req_wstrb = '1;
      checkOutput({tag, " req_ready wait"}, 64'(req_ready), 64'd0);
      checkOutput({tag, " resp_valid wait"}, 64'(resp_valid), 64'd0);
      @(posedge clk); #1;
      checkOutput({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
      checkOutput({tag, " rdata"}, resp_rdata, exp_rdata);
      checkOutput({tag, " err"}, 64'(resp_err), 64'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         checkOutput({tag, " held valid"}, 64'(resp_valid), 64'd1);
         checkOutput({tag, " held rdata"}, resp_rdata, exp_rdata);
         checkOutput({tag, " held req_ready"}, 64'(req_ready), 64'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checkOutput({tag, " valid after hs"}, 64'(resp_valid), 64'd0);
      checkOutput({tag, " ready after hs"}, 64'(req_ready), 64'd1);
      checkOutput({tag, " rdata after hs"}, resp_rdata, 64'd0);
      checkOutput({tag, " err after hs"}, 64'(resp_err), 64'd0);
   endtask

   initial begin
      clk        = 1'b0;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_wstrb  = '0;
      resp_ready = 1'b0;

      #12;
      checkOutput("in reset req_ready", 64'(req_ready), 64'd0);
      checkOutput("in reset resp_valid", 64'(resp_valid), 64'd0);
      #10 reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("post reset req_ready", 64'(req_ready), 64'd1);
      checkOutput("post reset resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("post reset rdata", resp_rdata, 64'd0);

      applyStimulus("st 0x50", 1'b1, 64'h50, 64'h7, 8'hFF, 0, 1'b0, 64'd0, 1'b0);
      applyStimulus("ld 0x50", 1'b0, 64'h50, 64'h0, 8'h00, 0, 1'b0, 64'h7, 1'b0);

      applyStimulus("st 0x08 full", 1'b1, 64'h08, 64'h1122334455667788, 8'hFF, 0, 1'b0, 64'd0, 1'b0);
      applyStimulus("st 0x08 low", 1'b1, 64'h08, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 1'b0, 64'd0, 1'b0);
      applyStimulus("ld 0x08", 1'b0, 64'h08, 64'h0, 8'h00, 0, 1'b0, 64'h11223344AAAAAAAA, 1'b0);

      applyStimulus("ld 0x50 bp", 1'b0, 64'h50, 64'h0, 8'h00, 5, 1'b0, 64'h7, 1'b0);
      applyStimulus("ld 0x50 early rdy", 1'b0, 64'h50, 64'h0, 8'h00, 0, 1'b1, 64'h7, 1'b0);

      applyStimulus("st 0x54 misalign", 1'b1, 64'h54, 64'hFFFF, 8'hFF, 0, 1'b0, 64'd0, 1'b1);
      applyStimulus("st 0x200 range", 1'b1, 64'h200, 64'hDEAD, 8'hFF, 0, 1'b0, 64'd0, 1'b1);
      applyStimulus("st hi bit", 1'b1, 64'h8000000000000050, 64'hBEEF, 8'hFF, 0, 1'b0, 64'd0, 1'b1);
      applyStimulus("ld 0x51 misalign", 1'b0, 64'h51, 64'h0, 8'h00, 0, 1'b0, 64'd0, 1'b1);
      applyStimulus("ld 0x50 after err", 1'b0, 64'h50, 64'h0, 8'h00, 0, 1'b0, 64'h7, 1'b0);

      applyStimulus("st 0x50 no strb", 1'b1, 64'h50, 64'h1234, 8'h00, 0, 1'b0, 64'd0, 1'b0);
      applyStimulus("ld 0x50 after nostrb", 1'b0, 64'h50, 64'h0, 8'h00, 0, 1'b0, 64'h7, 1'b0);

      applyStimulus("st top word", 1'b1, 64'h1F8, 64'hCAFEF00D12345678, 8'hFF, 0, 1'b0, 64'd0, 1'b0);
      applyStimulus("ld top word", 1'b0, 64'h1F8, 64'h0, 8'h00, 0, 1'b0, 64'hCAFEF00D12345678, 1'b0);

      // Reset lands while the store response is still pending.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 64'h10;
      req_wdata = 64'h5;
      req_wstrb = 8'hFF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("rst wait req_ready", 64'(req_ready), 64'd0);
      reset = 1'b1;
      #1;
      checkOutput("rst async resp_valid", 64'(resp_valid), 64'd0);
      checkOutput("rst async req_ready", 64'(req_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("rst held resp_valid", 64'(resp_valid), 64'd0);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("rst release req_ready", 64'(req_ready), 64'd1);
      checkOutput("rst release resp_valid", 64'(resp_valid), 64'd0);
      applyStimulus("ld 0x10 after rst", 1'b0, 64'h10, 64'h0, 8'h00, 0, 1'b0, 64'h5, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/dmem_handshake.md
Name: dmem_handshake

Overview:
Multi-cycle data-memory responder for the 64-bit RISC-V core. It services load/store requests over a valid/ready request channel and returns results over a valid/ready response channel after a programmable latency. It sits between the CPU data port and the data RAM, and replaces the zero-latency combinational data memory when stall-capable cores are built.

Parameters:
DEPTH, 64, number of 64-bit doublewords stored; must be a power of 2.
LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.
INIT_FILE, "dmem.dat", hex image path; used only when DMEM_INIT_EN is defined.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  64  byte address
req_wdata  input  64  store data
req_wstrb  input  8  byte enables for stores; bit i covers wdata[8i+7:8i]
resp_valid  output  1  response present
resp_ready  input  1  requester accepts the response
resp_rdata  output  64  load data; 0 for stores and errors
resp_err  output  1  request was misaligned or out of range

Behaviour:
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. req_ready=0 while reset is high. RAM contents are not reset.
- Word index = req_addr[$clog2(DEPTH)+2:3].
- Error condition: req_addr[2:0]!=0, or any bit of req_addr[63:$clog2(DEPTH)+3] set.
- FSM IDLE: req_ready=1. On req_valid&&req_ready at a rising edge (the accept edge):
  - Store without error: RAM[idx] is updated byte-wise per req_wstrb at that edge.
  - Load: resp_rdata is registered from RAM[idx] at that edge.
  - Error: no RAM write; registered rdata=0, err=1.
  - Counter loads LATENCY-1. Next state is RESP if LATENCY==1, else WAIT.
- FSM WAIT: req_ready=0. Counter decrements each edge. Transition to RESP on the edge where counter==1. Net effect: resp_valid rises exactly LATENCY cycles after the accept cycle.
- FSM RESP: resp_valid=1 and req_ready=0.
  - resp_rdata and resp_err stay stable until resp_valid&&resp_ready.
  - On that handshake edge: next state IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
  - No same-cycle request acceptance. Peak throughput is one request per LATENCY+1 cycles.
- Store responses: resp_rdata=0, resp_err=0 unless the error condition holds.
- Read-after-write: a load accepted after a completed store to the same word returns the new data.
- req_wstrb=0 on a store: no bytes change; a normal response is still returned.
- Inputs other than req_valid are don't-care when req_valid=0.
- Reset mid-operation (WAIT or RESP): the pending response is dropped and the FSM returns to IDLE. A store already committed at its accept edge remains in RAM.
- resp_ready held high in WAIT has no effect.

Optional Feature:
DMEM_INIT_EN: when defined, RAM is initialised at time 0 by $readmemh(INIT_FILE). When undefined, RAM powers up X and holds only what has been stored. Interface and timing are identical either way.

Test Plan:
- Reset then idle: reset high for 22 ns, then low -> req_ready=1, resp_valid=0, resp_rdata=0 on the first post-reset edge.
- Store then load, LATENCY=2: store addr 0x50, data 0x7, wstrb 0xFF; then load 0x50 -> store response (rdata=0, err=0) 2 cycles after accept; load response rdata=0x7, err=0, 2 cycles after its accept.
- Byte strobes: store 0x1122334455667788 to 0x08 with wstrb 0xFF; then store 0xAAAAAAAAAAAAAAAA with wstrb 0x0F; load 0x08 -> rdata=0x11223344AAAAAAAA.
- Backpressure: load 0x50 with resp_ready low for 5 cycles -> resp_valid stays 1, rdata=0x7 stable, req_ready=0; handshake on cycle 6 -> IDLE next cycle.
- Errors: store to 0x54 (misaligned) and store to 0x200 (DEPTH=64, out of range) -> err=1, rdata=0, and a following load of 0x50 still returns 0x7.
- Reset in WAIT: accept a store to 0x10 of 0x5, assert reset 1 cycle later -> resp_valid never rises; after release, load 0x10 returns 0x5.
